// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the fetch-side branch predictor.
//   br_type_e  : branch class codes carried in both prediction and resolution records
//   p_result_t : per-instruction prediction record produced at fetch
//   b_result_t : resolution/correction record returned by the EXE branch resolver
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    BIsNone = 2'd0,
    BIsImme = 2'd1,
    BIsCall = 2'd2,
    BIsRetn = 2'd3
  } br_type_e;

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic [1:0]  count;
    br_type_e    br_type;
    logic        taken;
    logic [31:0] target;
  } p_result_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    br_type_e    br_type;
    logic        taken;
    logic [31:0] target;
    logic        hit;
    logic [1:0]  count;
  } b_result_t;

  // Counter value given to a freshly allocated entry (weakly taken).
  localparam logic [1:0] CntInit = 2'b10;

  // 2-bit saturating counter step.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_unit_return_addr_stack.sv
// Circular return-address stack.
//   clk_i, rst_i          : clock, async active-high reset (pointer/count/storage cleared)
//   push_i, push_addr_i   : push an address; when full the oldest entry is overwritten
//   pop_i                 : pop; ignored when empty
//   load_i, load_*_i      : replace the whole state, then apply this cycle's push/pop
//   stack_o, ptr_o, cnt_o : current state (ptr_o is the next free slot, top is ptr_o-1)
module branch_predict_unit_return_addr_stack #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [31:0]           push_addr_i,
  input  logic                  load_i,
  input  logic [Depth-1:0][31:0] load_stack_i,
  input  logic [PtrW-1:0]       load_ptr_i,
  input  logic [CntW-1:0]       load_cnt_i,
  output logic [Depth-1:0][31:0] stack_o,
  output logic [PtrW-1:0]       ptr_o,
  output logic [CntW-1:0]       cnt_o
);

  logic [Depth-1:0][31:0] stack_q, stack_d, base_stack;
  logic [PtrW-1:0]        ptr_q, ptr_d, base_ptr;
  logic [CntW-1:0]        cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_stack = load_i ? load_stack_i : stack_q;
    base_ptr   = load_i ? load_ptr_i   : ptr_q;
    base_cnt   = load_i ? load_cnt_i   : cnt_q;
    stack_d    = base_stack;
    ptr_d      = base_ptr;
    cnt_d      = base_cnt;
    if (push_i) begin
      stack_d[base_ptr] = push_addr_i;
      ptr_d             = base_ptr + PtrW'(1);
      if (base_cnt != CntW'(Depth)) cnt_d = base_cnt + CntW'(1);
    end else if (pop_i && (base_cnt != '0)) begin
      ptr_d = base_ptr - PtrW'(1);
      cnt_d = base_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stack_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stack_o = stack_q;
  assign ptr_o   = ptr_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: direct-mapped BTB plus speculative/resolved return-address stacks.
//   clk, rst        : clock, async active-high reset
//   lk_valid/lk_pc  : lookup request from PC generation; lk_stall freezes outputs and spec RAS
//   pr_*            : registered prediction for the PC looked up in the previous cycle
//   up_*            : resolution record from EXE (trains BTB, drives resolved RAS)
//   up_fail         : misprediction flush; spec RAS reloaded from resolved RAS, lookup dropped
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned INDEX_W   = 8,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  input  logic        lk_stall,
  output logic        pr_valid,
  output logic        pr_hit,
  output logic [1:0]  pr_count,
  output logic [1:0]  pr_type,
  output logic        pr_taken,
  output logic [31:0] pr_target,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic [1:0]  up_type,
  input  logic        up_taken,
  input  logic [31:0] up_target,
  input  logic        up_hit,
  input  logic [1:0]  up_count,
  input  logic        up_fail
);

  localparam int unsigned Entries = 1 << INDEX_W;
  localparam int unsigned RasPtrW = $clog2(RAS_DEPTH);
  localparam int unsigned RasCntW = RasPtrW + 1;

  b_result_t up;
  assign up = '{valid: up_valid, pc: up_pc, br_type: br_type_e'(up_type), taken: up_taken,
                target: up_target, hit: up_hit, count: up_count};

  // BTB: only the valid bits are reset; data arrays are qualified by them.
  logic [Entries-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]   btb_tag_q    [Entries];
  br_type_e           btb_type_q   [Entries];
  logic [31:0]        btb_target_q [Entries];
  logic [1:0]         btb_cnt_q    [Entries];

  logic [INDEX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic [31:0]        lk_seq, up_seq;
  logic               lk_hit, lk_fire, lk_push, lk_pop;
  br_type_e           lk_type;
  p_result_t          lk_res, pr_q, pr_d;

  logic                         res_push, res_pop, spec_push, spec_pop;
  logic [31:0]                  spec_push_addr, spec_top;
  logic [RAS_DEPTH-1:0][31:0]   spec_stack, res_stack;
  logic [RasPtrW-1:0]           spec_ptr, res_ptr, spec_top_ptr;
  logic [RasCntW-1:0]           spec_cnt, res_cnt;

  logic       wr_en, wr_target;
  logic [1:0] wr_cnt;

  assign lk_idx  = lk_pc[INDEX_W+1:2];
  assign lk_tag  = lk_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign up_idx  = up.pc[INDEX_W+1:2];
  assign up_tag  = up.pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign lk_seq  = lk_pc + 32'd8;
  assign up_seq  = up.pc + 32'd8;
  assign lk_type = btb_type_q[lk_idx];
  assign lk_hit  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);

  assign spec_top_ptr = spec_ptr - RasPtrW'(1);
  assign spec_top     = spec_stack[spec_top_ptr];

  // Lookup reads the pre-update arrays, so a same-cycle write is not visible yet.
  always_comb begin
    lk_res        = '0;
    lk_res.valid  = 1'b1;
    lk_res.target = lk_seq;
    if (lk_hit) begin
      lk_res.hit     = 1'b1;
      lk_res.count   = btb_cnt_q[lk_idx];
      lk_res.br_type = lk_type;
      case (lk_type)
        BIsCall, BIsRetn: lk_res.taken = 1'b1;
        BIsImme:          lk_res.taken = btb_cnt_q[lk_idx][1];
        default:          lk_res.taken = 1'b0;
      endcase
      if (lk_res.taken) begin
        lk_res.target = (lk_type == BIsRetn && spec_cnt != '0) ? spec_top : btb_target_q[lk_idx];
      end
    end
  end

  // Flush wins over stall; a stall otherwise holds the previous prediction.
  assign lk_fire = lk_valid && !lk_stall && !up_fail;

  always_comb begin
    pr_d = pr_q;
    if (up_fail || (!lk_stall && !lk_valid)) pr_d = '0;
    else if (!lk_stall)                      pr_d = lk_res;
  end

  assign lk_push  = lk_fire && lk_hit && (lk_type == BIsCall);
  assign lk_pop   = lk_fire && lk_hit && (lk_type == BIsRetn);
  assign res_push = up.valid && (up.br_type == BIsCall);
  assign res_pop  = up.valid && (up.br_type == BIsRetn);

  // On flush the spec stack loads the resolved state and replays the resolver's own
  // push/pop, landing on the resolved stack's post-update state.
  assign spec_push      = up_fail ? res_push : lk_push;
  assign spec_pop       = up_fail ? res_pop  : lk_pop;
  assign spec_push_addr = up_fail ? up_seq   : lk_seq;

  always_comb begin
    btb_valid_d = btb_valid_q;
    wr_en       = 1'b0;
    wr_target   = 1'b0;
    wr_cnt      = CntInit;
    if (up.valid) begin
      if (up.br_type == BIsNone) begin
        if (up.hit) btb_valid_d[up_idx] = 1'b0;
      end else if (up.hit) begin
        wr_en     = 1'b1;
        wr_target = up.taken;
        wr_cnt    = cnt_step(up.count, up.taken);
      end else if (up.taken) begin
        wr_en               = 1'b1;
        wr_target           = 1'b1;
        btb_valid_d[up_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q        <= '0;
      btb_valid_q <= '0;
    end else begin
      pr_q        <= pr_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      btb_tag_q[up_idx]  <= up_tag;
      btb_type_q[up_idx] <= up.br_type;
      btb_cnt_q[up_idx]  <= wr_cnt;
      if (wr_target) btb_target_q[up_idx] <= up.target;
    end
  end

  branch_predict_unit_return_addr_stack #(.Depth(RAS_DEPTH)) u_res_ras (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (res_push),
    .pop_i        (res_pop),
    .push_addr_i  (up_seq),
    .load_i       (1'b0),
    .load_stack_i ('0),
    .load_ptr_i   ('0),
    .load_cnt_i   ('0),
    .stack_o      (res_stack),
    .ptr_o        (res_ptr),
    .cnt_o        (res_cnt)
  );

  branch_predict_unit_return_addr_stack #(.Depth(RAS_DEPTH)) u_spec_ras (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (spec_push),
    .pop_i        (spec_pop),
    .push_addr_i  (spec_push_addr),
    .load_i       (up_fail),
    .load_stack_i (res_stack),
    .load_ptr_i   (res_ptr),
    .load_cnt_i   (res_cnt),
    .stack_o      (spec_stack),
    .ptr_o        (spec_ptr),
    .cnt_o        (spec_cnt)
  );

  assign pr_valid  = pr_q.valid;
  assign pr_hit    = pr_q.hit;
  assign pr_count  = pr_q.count;
  assign pr_type   = pr_q.br_type;
  assign pr_taken  = pr_q.taken;
  assign pr_target = pr_q.target;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by random traffic,
// all compared against a behavioural model (array BTB, queue-based return stacks).
module tb_branch_predict_unit;

  localparam int TNone = 0, TImme = 1, TCall = 2, TRetn = 3;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid, lk_stall, up_valid, up_taken, up_hit, up_fail;
  logic [31:0] lk_pc, up_pc, up_target;
  logic [1:0]  up_type, up_count;
  logic        pr_valid, pr_hit, pr_taken;
  logic [1:0]  pr_count, pr_type;
  logic [31:0] pr_target;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_stall(lk_stall),
    .pr_valid(pr_valid), .pr_hit(pr_hit), .pr_count(pr_count), .pr_type(pr_type),
    .pr_taken(pr_taken), .pr_target(pr_target), .up_valid(up_valid), .up_pc(up_pc),
    .up_type(up_type), .up_taken(up_taken), .up_target(up_target), .up_hit(up_hit),
    .up_count(up_count), .up_fail(up_fail)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model
  bit          m_valid [256];
  int          m_tag   [256];
  int          m_type  [256];
  logic [31:0] m_tgt   [256];
  int          m_cnt   [256];
  logic [31:0] spec_q[$];
  logic [31:0] res_q[$];
  logic [31:0] e_valid, e_hit, e_cnt, e_type, e_taken, e_tgt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 10) % 1024);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic ras_push(input bit resolved, input logic [31:0] a);
    if (resolved) begin
      res_q.push_back(a);
      if (res_q.size() > Depth) void'(res_q.pop_front());
    end else begin
      spec_q.push_back(a);
      if (spec_q.size() > Depth) void'(spec_q.pop_front());
    end
  endtask

  task automatic ras_pop(input bit resolved);
    if (resolved) begin
      if (res_q.size() > 0) void'(res_q.pop_back());
    end else begin
      if (spec_q.size() > 0) void'(spec_q.pop_back());
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    spec_q.delete();
    res_q.delete();
    {e_valid, e_hit, e_cnt, e_type, e_taken, e_tgt} = '0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    int  li, ui, lty, c;
    bit  lhit;
    li   = idx_of(lk_pc);
    lhit = model_hit(lk_pc);
    lty  = m_type[li];
    if (up_fail || (!lk_stall && !lk_valid)) begin
      {e_valid, e_hit, e_cnt, e_type, e_taken, e_tgt} = '0;
    end else if (!lk_stall) begin
      e_valid = 1;
      e_hit   = lhit;
      e_cnt   = lhit ? m_cnt[li] : 0;
      e_type  = lhit ? lty : TNone;
      e_taken = lhit && (lty == TCall || lty == TRetn || (lty == TImme && m_cnt[li] >= 2));
      if (!e_taken)                              e_tgt = lk_pc + 32'd8;
      else if (lty == TRetn && spec_q.size() > 0) e_tgt = spec_q[$];
      else                                       e_tgt = m_tgt[li];
    end
    if (lk_valid && !lk_stall && !up_fail && lhit) begin
      if (lty == TCall)      ras_push(1'b0, lk_pc + 32'd8);
      else if (lty == TRetn) ras_pop(1'b0);
    end
    if (up_valid) begin
      ui = idx_of(up_pc);
      if (int'(up_type) == TNone) begin
        if (up_hit) m_valid[ui] = 1'b0;
      end else if (up_hit) begin
        m_tag[ui]  = tag_of(up_pc);
        m_type[ui] = int'(up_type);
        if (up_taken) m_tgt[ui] = up_target;
        c = int'(up_count) + (up_taken ? 1 : -1);
        m_cnt[ui] = (c > 3) ? 3 : (c < 0) ? 0 : c;
      end else if (up_taken) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = tag_of(up_pc);
        m_type[ui]  = int'(up_type);
        m_tgt[ui]   = up_target;
        m_cnt[ui]   = 2;
      end
      if (int'(up_type) == TCall)      ras_push(1'b1, up_pc + 32'd8);
      else if (int'(up_type) == TRetn) ras_pop(1'b1);
    end
    if (up_fail) spec_q = res_q;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("pr_valid", 32'(pr_valid), e_valid);
    check("pr_hit", 32'(pr_hit), e_hit);
    check("pr_count", 32'(pr_count), e_cnt);
    check("pr_type", 32'(pr_type), e_type);
    check("pr_taken", 32'(pr_taken), e_taken);
    check("pr_target", pr_target, e_tgt);
  endtask

  task automatic idle();
    lk_valid = 0; lk_pc = '0; lk_stall = 0;
    up_valid = 0; up_pc = '0; up_type = 2'(TNone); up_taken = 0; up_target = '0;
    up_hit = 0; up_count = '0; up_fail = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle();
    lk_valid = 1; lk_pc = pc;
    cycle();
  endtask

  task automatic update(input logic [31:0] pc, input int ty, input bit tk, input logic [31:0] tgt,
                        input bit hit, input logic [1:0] cnt);
    idle();
    up_valid = 1; up_pc = pc; up_type = 2'(ty); up_taken = tk; up_target = tgt;
    up_hit = hit; up_count = cnt;
    cycle();
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(pr_valid), 0);
    check("rst_target", pr_target, 0);
    rst = 0;

    // Cold lookup misses and predicts the sequential PC
    lookup(32'hBFC0_0000);
    check("boot_hit", 32'(pr_hit), 0);
    check("boot_target", pr_target, 32'hBFC0_0008);
    idle();
    cycle();

    // Allocate an Imme entry, then train it down to strongly not-taken
    update(32'h8000_1000, TImme, 1'b1, 32'h8000_2000, 1'b0, 2'd0);
    lookup(32'h8000_1000);
    check("imme_cnt", 32'(pr_count), 2);
    check("imme_target", pr_target, 32'h8000_2000);
    update(32'h8000_1000, TImme, 1'b0, 32'h0, 1'b1, 2'd2);
    update(32'h8000_1000, TImme, 1'b0, 32'h0, 1'b1, 2'd1);
    lookup(32'h8000_1000);
    check("imme_nt_cnt", 32'(pr_count), 0);
    check("imme_nt_taken", 32'(pr_taken), 0);
    check("imme_nt_target", pr_target, 32'h8000_1008);

    // Call/return pairing, then overflow of the speculative stack
    update(32'h8000_0400, TRetn, 1'b1, 32'h8000_0F00, 1'b0, 2'd0);
    for (int k = 0; k < 9; k++) update(32'h8000_0100 + 32'(4 * k), TCall, 1'b1, 32'h8000_0400,
                                       1'b0, 2'd0);
    lookup(32'h8000_0100);
    lookup(32'h8000_0400);
    check("ret_target", pr_target, 32'h8000_0108);
    for (int k = 0; k < 9; k++) lookup(32'h8000_0100 + 32'(4 * k));
    for (int k = 0; k < 8; k++) lookup(32'h8000_0400);
    check("ras_oldest_kept", pr_target, 32'h8000_010C);
    lookup(32'h8000_0400);
    check("ras_overwritten", pr_target, 32'h8000_0F00);

    // Flush restores an empty resolved stack into the speculative one
    update(32'h0000_0008, TCall, 1'b1, 32'h8000_0400, 1'b0, 2'd0);
    update(32'h0000_0018, TCall, 1'b1, 32'h8000_0400, 1'b0, 2'd0);
    for (int k = 0; k < 8; k++) update(32'h8000_0400, TRetn, 1'b1, 32'h8000_0F00, 1'b1, 2'd3);
    lookup(32'h0000_0008);
    lookup(32'h0000_0018);
    idle();
    lk_valid = 1; lk_pc = 32'h0000_0008;
    up_valid = 1; up_type = 2'(TNone); up_fail = 1;
    cycle();
    check("flush_drop", 32'(pr_valid), 0);
    lookup(32'h8000_0400);
    check("flush_ret", pr_target, 32'h8000_0F00);

    // Same-index lookup and update: old entry now, new entry next time
    update(32'h8000_0204, TImme, 1'b1, 32'h8000_5000, 1'b0, 2'd0);
    idle();
    lk_valid = 1; lk_pc = 32'h8000_0204;
    up_valid = 1; up_pc = 32'h8000_0204; up_type = 2'(TImme); up_taken = 1;
    up_target = 32'h8000_6000; up_hit = 1; up_count = 2'd2;
    cycle();
    check("rw_old_target", pr_target, 32'h8000_5000);
    lookup(32'h8000_0204);
    check("rw_new_target", pr_target, 32'h8000_6000);
    check("rw_new_cnt", 32'(pr_count), 3);

    // Stall holds the prediction and freezes the speculative stack
    lookup(32'h8000_0204);
    for (int k = 0; k < 3; k++) begin
      idle();
      lk_valid = 1; lk_pc = 32'h8000_0100; lk_stall = 1;
      cycle();
      check("stall_hold", pr_target, 32'h8000_6000);
    end
    lookup(32'h8000_0400);
    check("stall_ras", pr_target, 32'h8000_0F00);
    lookup(32'h8000_0204);
    idle();
    lk_valid = 1; lk_pc = 32'h8000_0100; lk_stall = 1;
    cycle();
    rst = 1;
    #2;
    check("async_valid", 32'(pr_valid), 0);
    check("async_hit", 32'(pr_hit), 0);
    check("async_count", 32'(pr_count), 0);
    check("async_taken", 32'(pr_taken), 0);
    check("async_target", pr_target, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    idle();
    cycle();

    // Random traffic over a small PC pool so hits, aliasing and RAS activity are frequent
    for (int n = 0; n < 3000; n++) begin
      idle();
      lk_valid  = ($urandom_range(0, 9) < 8);
      lk_stall  = ($urandom_range(0, 9) == 0);
      lk_pc     = 32'h8000_0000 | (32'($urandom_range(0, 1)) << 10) |
                  (32'($urandom_range(0, 15)) << 2);
      up_valid  = $urandom_range(0, 1);
      up_pc     = 32'h8000_0000 | (32'($urandom_range(0, 1)) << 10) |
                  (32'($urandom_range(0, 15)) << 2);
      up_type   = 2'($urandom_range(0, 3));
      up_taken  = $urandom_range(0, 1);
      up_target = 32'h9000_0000 | (32'($urandom_range(0, 255)) << 2);
      up_hit    = ($urandom_range(0, 4) != 0) ? model_hit(up_pc) : 1'($urandom_range(0, 1));
      up_count  = 2'($urandom_range(0, 3));
      up_fail   = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
